// File: rtl/wb_select.sv
// Writeback-select stage: picks one of NSRC operands, waits for memory data, extends loads,
// and drives a registered register-file write port. Optional memory-wait timeout: WB_TIMEOUT_EN.
module wb_select #(
    parameter int DATA_W   = 32,
    parameter int NSRC     = 4,
    parameter int MEM_SLOT = 1,
    parameter int REG_AW   = 5,
    parameter int TIMEOUT  = 16,
    localparam int SEL_W   = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic                   reg_write,
    input  logic [REG_AW-1:0]      dest,
    input  logic [2:0]             load_type,
    input  logic [OFF_W-1:0]       byte_off,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   wb_en,
    output logic [REG_AW-1:0]      wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   busy,
    output logic                   err
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t              state, state_d;
    logic                lat_rw;
    logic [REG_AW-1:0]   lat_dest;
    logic [2:0]          lat_lt;
    logic [OFF_W-1:0]    lat_off;
    logic                accept, lat_load, fire, fire_we, err_d;
    logic [REG_AW-1:0]   fire_addr;
    logic [DATA_W-1:0]   fire_data, sel_data;

    // Little-endian lanes; unknown load types fall back to a full-word load.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [2:0] lt,
                                                 input logic [OFF_W-1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[int'(off) * 8 +: 8];
        h = d[int'(off >> 1) * 16 +: 16];
        case (lt)
            3'b001:  return {{(DATA_W - 16){h[15]}}, h};
            3'b010:  return {{(DATA_W - 16){1'b0}}, h};
            3'b011:  return {{(DATA_W - 8){b[7]}}, b};
            3'b100:  return {{(DATA_W - 8){1'b0}}, b};
            default: return d;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == WAIT_MEM);

    // Out-of-range selects match no slot and read as zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++)
            if (src_sel == SEL_W'(k)) sel_data = src_data[k*DATA_W +: DATA_W];
    end

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             limit;
    assign limit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || lat_load) cnt <= '0;
        else if (state == WAIT_MEM) cnt <= cnt + 1'b1;
    end
`else
    logic limit;
    assign limit = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        lat_load  = 1'b0;
        fire      = 1'b0;
        fire_we   = reg_write;
        fire_addr = dest;
        fire_data = sel_data;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (src_sel != SEL_W'(MEM_SLOT)) begin
                        fire = 1'b1;
                    end else if (mem_rvalid) begin
                        fire      = 1'b1;
                        fire_data = extend(mem_rdata, load_type, byte_off);
                    end else begin
                        lat_load = 1'b1;
                        state_d  = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                fire_we   = lat_rw;
                fire_addr = lat_dest;
                fire_data = extend(mem_rdata, lat_lt, lat_off);
                // Data arriving on the limit cycle still wins over the timeout.
                if (mem_rvalid) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end else if (limit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
            lat_rw   <= 1'b0;
            lat_dest <= '0;
            lat_lt   <= '0;
            lat_off  <= '0;
        end else begin
            state <= state_d;
            err   <= err_d;
            wb_en <= fire && fire_we && (fire_addr != '0);
            if (fire) begin
                wb_addr <= fire_addr;
                wb_data <= fire_data;
            end
            if (lat_load) begin
                lat_rw   <= reg_write;
                lat_dest <= dest;
                lat_lt   <= load_type;
                lat_off  <= byte_off;
            end
        end
    end
endmodule

// File: tb/tb_wb_select.sv
// Directed self-checking bench for wb_select (default parameters).
module tb_wb_select;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  src_sel;
    logic [127:0] src_data;
    logic        reg_write;
    logic [4:0]  dest;
    logic [2:0]  load_type;
    logic [1:0]  byte_off;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    wb_select dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_sel(src_sel), .src_data(src_data), .reg_write(reg_write), .dest(dest),
        .load_type(load_type), .byte_off(byte_off), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] val, input logic rw,
                         input logic [4:0] d, input logic [2:0] lt, input logic [1:0] off,
                         input logic [31:0] rdata, input logic rv);
        in_valid   = 1'b1;
        src_sel    = sel;
        src_data   = '0;
        src_data[int'(sel)*32 +: 32] = val;
        reg_write  = rw;
        dest       = d;
        load_type  = lt;
        byte_off   = off;
        mem_rdata  = rdata;
        mem_rvalid = rv;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'd0, 32'hDEADBEEF, 1'b1, 5'd3, 3'd0, 2'd0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({wb_en, wb_addr, wb_data, busy, err, in_ready} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc%0d got en=%b addr=%h data=%h busy=%b err=%b rdy=%b exp all 0",
                         i, wb_en, wb_addr, wb_data, busy, err, in_ready);
            end
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready got %b exp 1", in_ready);
        end
        drive(2'd0, 32'h12345678, 1'b1, 5'd5, 3'd0, 2'd0, 32'h0, 1'b0);
        cyc();
        idle_inputs();
        n_cmp++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd5, 32'h12345678}) begin
            n_bad++;
            $display("FAIL first_op got en=%b addr=%0d data=%h exp en=1 addr=5 data=12345678",
                     wb_en, wb_addr, wb_data);
        end
        cyc();
        n_cmp++;
        if ({wb_en, wb_addr, wb_data} !== {1'b0, 5'd5, 32'h12345678}) begin
            n_bad++;
            $display("FAIL first_op_hold got en=%b addr=%0d data=%h exp en=0 addr=5 data=12345678",
                     wb_en, wb_addr, wb_data);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  lt  [6] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd7};
        logic [1:0]  off [6] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF,
                                 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
        for (int i = 0; i < 6; i++) begin
            drive(2'd1, 32'h0, 1'b1, 5'(10 + i), lt[i], off[i], 32'h80FF7F01, 1'b1);
            cyc();
            n_cmp++;
            if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'(10 + i), exp[i]}) begin
                n_bad++;
                $display("FAIL load_ext[%0d] got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h",
                         i, wb_en, wb_addr, wb_data, 10 + i, exp[i]);
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_delayed_mem();
        drive(2'd1, 32'h0, 1'b1, 5'd9, 3'd0, 2'd0, 32'h0, 1'b0);
        cyc();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hCAFEBABE;
            end
            n_cmp++;
            if ({busy, in_ready, wb_en} !== 3'b100) begin
                n_bad++;
                $display("FAIL delayed_wait[%0d] got busy=%b rdy=%b en=%b exp busy=1 rdy=0 en=0",
                         i, busy, in_ready, wb_en);
            end
            if (i < 4) cyc();
        end
        cyc();
        mem_rdata = 32'h11111111;
        n_cmp++;
        if ({wb_en, wb_addr, wb_data, busy, in_ready} !== {1'b1, 5'd9, 32'hCAFEBABE, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL delayed_write got en=%b addr=%0d data=%h busy=%b rdy=%b exp en=1 addr=9 data=cafebabe busy=0 rdy=1",
                     wb_en, wb_addr, wb_data, busy, in_ready);
        end
        cyc();
        mem_rvalid = 1'b0;
        n_cmp++;
        if ({wb_en, wb_data, busy} !== {1'b0, 32'hCAFEBABE, 1'b0}) begin
            n_bad++;
            $display("FAIL stray_rvalid got en=%b data=%h busy=%b exp en=0 data=cafebabe busy=0",
                     wb_en, wb_data, busy);
        end
    endtask

    task automatic test_zero_and_back_to_back();
        logic [1:0]  sel [3] = '{2'd0, 2'd2, 2'd3};
        logic [31:0] val [3] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        drive(2'd2, 32'h00000011, 1'b1, 5'd0, 3'd0, 2'd0, 32'h0, 1'b0);
        cyc();
        n_cmp++;
        if ({wb_en, wb_addr, wb_data} !== {1'b0, 5'd0, 32'h00000011}) begin
            n_bad++;
            $display("FAIL write_r0 got en=%b addr=%0d data=%h exp en=0 addr=0 data=00000011",
                     wb_en, wb_addr, wb_data);
        end
        drive(2'd3, 32'h00000077, 1'b0, 5'd7, 3'd0, 2'd0, 32'h0, 1'b0);
        cyc();
        n_cmp++;
        if ({wb_en, wb_addr, wb_data} !== {1'b0, 5'd7, 32'h00000077}) begin
            n_bad++;
            $display("FAIL no_regwrite got en=%b addr=%0d data=%h exp en=0 addr=7 data=00000077",
                     wb_en, wb_addr, wb_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive(sel[i], val[i], 1'b1, 5'(i + 1), 3'd0, 2'd0, 32'h0, 1'b0);
            cyc();
            n_cmp++;
            if ({wb_en, wb_addr, wb_data, in_ready} !== {1'b1, 5'(i + 1), val[i], 1'b1}) begin
                n_bad++;
                $display("FAIL b2b[%0d] got en=%b addr=%0d data=%h rdy=%b exp en=1 addr=%0d data=%h rdy=1",
                         i, wb_en, wb_addr, wb_data, in_ready, i + 1, val[i]);
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        drive(2'd1, 32'h0, 1'b1, 5'd12, 3'd0, 2'd0, 32'h0, 1'b0);
        cyc();
        idle_inputs();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midwait_busy got %b exp 1", busy);
        end
        rst_n = 1'b0;
        cyc();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        cyc();
        mem_rvalid = 1'b0;
        n_cmp++;
        if ({wb_en, busy, wb_data} !== {1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL midwait_discard got en=%b busy=%b data=%h exp en=0 busy=0 data=0",
                     wb_en, busy, wb_data);
        end
    endtask

    task automatic test_timeout();
        drive(2'd1, 32'h0, 1'b1, 5'd4, 3'd0, 2'd0, 32'h0, 1'b0);
        cyc();
        idle_inputs();
        for (int i = 1; i <= 16; i++) begin
            n_cmp++;
            if ({busy, err, wb_en} !== 3'b100) begin
                n_bad++;
                $display("FAIL timeout_wait[%0d] got busy=%b err=%b en=%b exp busy=1 err=0 en=0",
                         i, busy, err, wb_en);
            end
            cyc();
        end
`ifdef WB_TIMEOUT_EN
        n_cmp++;
        if ({err, wb_en, busy, in_ready} !== 4'b1001) begin
            n_bad++;
            $display("FAIL timeout_err got err=%b en=%b busy=%b rdy=%b exp err=1 en=0 busy=0 rdy=1",
                     err, wb_en, busy, in_ready);
        end
        cyc();
        n_cmp++;
        if ({err, wb_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_pulse got err=%b en=%b exp err=0 en=0", err, wb_en);
        end
`else
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({busy, err, in_ready} !== 3'b100) begin
                n_bad++;
                $display("FAIL no_timeout[%0d] got busy=%b err=%b rdy=%b exp busy=1 err=0 rdy=0",
                         i, busy, err, in_ready);
            end
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        src_sel = '0; src_data = '0; reg_write = 1'b0; dest = '0;
        load_type = '0; byte_off = '0; mem_rdata = '0;
        test_reset();
        test_load_ext();
        test_delayed_mem();
        test_zero_and_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_select.md
# wb_select

Parametrised writeback-select stage for the MIPS_32 pipeline, successor to the two-way ALU/memory writeback mux. It takes one of NSRC source operands per instruction, waits for memory-sourced operands to return, and applies load sign/zero extension. It presents a single registered register-file write port (enable, address, data) one cycle after the result is known, with a valid/ready handshake towards the upstream stage.

## Interface
- DATA_W, 32, datapath width; must be a multiple of 16 and ≥ 32
- NSRC, 4, number of source slots (ALU, memory, link PC+8, immediate by convention)
- MEM_SLOT, 1, slot index whose data comes from mem_rdata, not src_data
- REG_AW, 5, register address width
- TIMEOUT, 16, memory wait limit in cycles; used only with WB_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept (IDLE and rst_n high)
- src_sel  in  $clog2(NSRC)  selected source slot
- src_data  in  NSRC*DATA_W  flat source bus, slot k at [k*DATA_W +: DATA_W]
- reg_write  in  1  instruction writes a register
- dest  in  REG_AW  destination register
- load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others = LW
- byte_off  in  $clog2(DATA_W/8)  byte address of the load
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- wb_en  out  1  register-file write strobe, one-cycle pulse
- wb_addr  out  REG_AW  write address
- wb_data  out  DATA_W  write data
- busy  out  1  high in WAIT_MEM
- err  out  1  one-cycle timeout pulse; tied 0 without WB_TIMEOUT_EN

## Operation
- Accept when in_valid && in_ready. Latch src_sel, reg_write, dest, load_type, byte_off.
- States:
  - IDLE: ready for a new instruction.
  - WAIT_MEM: memory-sourced instruction accepted, no data yet.
- Non-memory slot (src_sel != MEM_SLOT): result is src_data slot src_sel, registered to the outputs. State stays IDLE.
- Memory slot, mem_rvalid high in the accept cycle: completes like a non-memory op, using the extended mem_rdata.
- Memory slot, mem_rvalid low: go to WAIT_MEM. In WAIT_MEM, the first mem_rvalid cycle registers the extended mem_rdata and returns to IDLE. mem_rvalid while IDLE with no memory op accepted is ignored.
- src_sel ≥ NSRC: result is 0.
- Extension, lanes little-endian:
  - Byte: lane byte_off.
  - Halfword: lane byte_off >> 1.
  - LB/LH: sign-extend to DATA_W.
  - LBU/LHU: zero-extend to DATA_W.
  - LW: pass the full word.
- wb_en = reg_write && dest != 0. A write to $0 is never strobed, but wb_addr and wb_data still update.
- All outputs, including wb_data, hold their value between strobes.

## Timing
- Reset (rst_n low at a clock edge):
  - Outputs: wb_en=0, wb_addr=0, wb_data=0, busy=0, err=0.
  - State → IDLE.
  - in_ready is 0 while rst_n is low.
- Reset during WAIT_MEM: the pending instruction is discarded and no wb_en follows.
- Latency:
  - Non-memory op: accept at cycle N → wb_en at N+1.
  - Memory op: mem_rvalid at cycle M → wb_en at M+1.
- Throughput: one non-memory op per cycle, back-to-back. in_ready is low for every cycle in WAIT_MEM.
- Accept in IDLE and the wb_en of the previous op may coincide; the previous op's outputs are not disturbed until the next edge.

## Configuration
- WB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_MEM and increments each cycle in WAIT_MEM.
  - If it reaches TIMEOUT without mem_rvalid: err pulses one cycle, wb_en stays 0 (instruction dropped), state → IDLE.
  - mem_rvalid on the same cycle as the limit wins: normal write, no err.
- WB_TIMEOUT_EN undefined: no counter. WAIT_MEM waits indefinitely. err is constant 0.

## Test plan
- Reset, non-memory op:
  - Stimulus: hold rst_n=0 3 cycles, then release. Send src_sel=0, src_data slot0=0x12345678, dest=5, reg_write=1.
  - Response: during reset all outputs are 0 and in_ready=0. Next cycle wb_en=1, wb_addr=5, wb_data=0x12345678.
- Load extension (4 loads, each with mem_rvalid=1 on the accept cycle and mem_rdata=0x80FF7F01):
  - LB, byte_off=3 → wb_data 0xFFFFFF80.
  - LBU, byte_off=2 → 0x000000FF.
  - LH, byte_off=2 → 0xFFFF80FF.
  - LHU, byte_off=0 → 0x00007F01.
- Delayed memory return:
  - Stimulus: memory op, dest=9, mem_rvalid arriving 4 cycles after accept.
  - Response: busy=1 and in_ready=0 for 4 cycles. wb_en one cycle after mem_rvalid with wb_addr=9. No extra wb_en.
- Writes to $0 and back-to-back ops:
  - Stimulus: dest=0, reg_write=1; then 3 back-to-back non-memory ops.
  - Response: $0 op gives wb_en=0. The 3 ops give wb_en on 3 consecutive cycles, data in order.
- Reset mid-wait: rst_n=0 during WAIT_MEM, mem_rvalid=1 the cycle after release → no wb_en, busy=0.
- Timeout, with WB_TIMEOUT_EN and TIMEOUT=16:
  - No mem_rvalid → err pulses after 16 WAIT_MEM cycles, no wb_en, in_ready=1 next cycle.
  - Without the macro, the same stimulus → busy stays 1 and err=0.
